pc_redirect_arb: RTL

Collects the single-cycle `pc_redirect_*` pulses from all execution sub-SICs (JR, branch, exception) and keeps the oldest one by issue age. It presents that redirect to fetch through a registered valid/ready handshake. After a redirect fires, it discards later-arriving redirects from the squashed younger path until fetch signals that the squash has completed. It sits between the sub-SIC outputs and the fetch PC mux.

---
 rtl/pc_redirect_arb_if.sv | 27 ++
 rtl/pc_redirect_arb.sv | 102 ++++++++++
 2 files changed

// File: rtl/pc_redirect_arb_if.sv
// Redirect bus between the sub-SIC redirect sources, the arbiter and the fetch PC mux.
// master: source/fetch side; slave: the arbiter.
interface pc_redirect_arb_if #(
  parameter int NUM_SRC  = 4,
  parameter int ID_WIDTH = 8
);
  logic [NUM_SRC-1:0]          src_valid;
  logic [NUM_SRC*32-1:0]       src_pc;
  logic [NUM_SRC*ID_WIDTH-1:0] src_issue_id;
  logic [ID_WIDTH-1:0]         base_id;
  logic                        squash_clr;
  logic                        redir_ready;
  logic                        redir_valid;
  logic [31:0]                 redir_pc;
  logic [ID_WIDTH-1:0]         redir_issue_id;
  logic                        redir_misalign;

  modport master (
    output src_valid, src_pc, src_issue_id, base_id, squash_clr, redir_ready,
    input  redir_valid, redir_pc, redir_issue_id, redir_misalign
  );

  modport slave (
    input  src_valid, src_pc, src_issue_id, base_id, squash_clr, redir_ready,
    output redir_valid, redir_pc, redir_issue_id, redir_misalign
  );
endinterface

// File: rtl/pc_redirect_arb.sv
// Keeps the oldest (by issue age) redirect pulse and offers it to fetch; fences off younger ones after a fire.
// Optional PC_REDIRECT_ALIGN_CHECK_EN adds a registered word-misalignment flag on the pending redirect.
module pc_redirect_arb #(
  parameter int NUM_SRC  = 4,
  parameter int ID_WIDTH = 8
) (
  input logic               clk,
  input logic               rst_n,
  pc_redirect_arb_if.slave  bus
);
  typedef logic [ID_WIDTH-1:0] id_t;
  typedef enum logic {IDLE, HOLD} state_t;

  state_t      state;
  logic [31:0] pend_pc;
  id_t         pend_id;
  logic        fence_valid;
  id_t         fence_id;

  logic        fire;
  logic        filt_valid;
  id_t         filt_age;
  id_t         pend_age;
  id_t         cand_id;
  id_t         cand_age;
  logic        win_valid;
  id_t         win_age;
  id_t         win_id;
  logic [31:0] win_pc;
  logic        load;

  // A firing redirect acts as the fence in its own cycle, so only strictly older pulses survive.
  always_comb begin
    fire       = (state == HOLD) && bus.redir_ready;
    filt_valid = fire || fence_valid;
    filt_age   = (fire ? pend_id : fence_id) - bus.base_id;
    pend_age   = pend_id - bus.base_id;
    cand_id    = '0;
    cand_age   = '0;
    win_valid  = 1'b0;
    win_age    = '0;
    win_id     = '0;
    win_pc     = '0;
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      cand_id  = bus.src_issue_id[i*ID_WIDTH +: ID_WIDTH];
      cand_age = cand_id - bus.base_id;
      if (bus.src_valid[i] && (!filt_valid || cand_age < filt_age) &&
          (!win_valid || cand_age < win_age)) begin
        win_valid = 1'b1;
        win_age   = cand_age;
        win_id    = cand_id;
        win_pc    = bus.src_pc[i*32 +: 32];
      end
    end
    load = win_valid && ((state == IDLE) || fire || (win_age < pend_age));
  end

`ifdef PC_REDIRECT_ALIGN_CHECK_EN
  logic pend_misalign;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      pend_pc     <= '0;
      pend_id     <= '0;
      fence_valid <= 1'b0;
      fence_id    <= '0;
`ifdef PC_REDIRECT_ALIGN_CHECK_EN
      pend_misalign <= 1'b0;
`endif
    end else begin
      if (load) begin
        pend_pc <= win_pc;
        pend_id <= win_id;
`ifdef PC_REDIRECT_ALIGN_CHECK_EN
        pend_misalign <= (win_pc[1:0] != 2'b00);
`endif
      end
      case (state)
        IDLE:    if (win_valid) state <= HOLD;
        HOLD:    if (fire && !win_valid) state <= IDLE;
        default: state <= IDLE;
      endcase
      if (fire) begin
        fence_valid <= 1'b1;
        fence_id    <= pend_id;
      end else if (bus.squash_clr) begin
        fence_valid <= 1'b0;
      end
    end
  end

  assign bus.redir_valid    = (state == HOLD);
  assign bus.redir_pc       = pend_pc;
  assign bus.redir_issue_id = pend_id;
`ifdef PC_REDIRECT_ALIGN_CHECK_EN
  assign bus.redir_misalign = (state == HOLD) && pend_misalign;
`else
  assign bus.redir_misalign = 1'b0;
`endif
endmodule
